// File: rtl/imem_boot_loader_if.sv
// Host byte-stream link into the boot loader.
// A byte moves on a rising clk edge where in_valid and in_ready are both 1; in_ready does not depend on in_valid.
interface imem_boot_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a framed program (length, payload, XOR checksum) into the instruction memory.
// Holds the core until the checksum verifies.
module imem_boot_loader #(
  parameter int MEM_BYTES = 128,
  parameter int AW        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_boot_loader_if.slave    host,
  input  logic                 reload_req,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [AW:0]          bytes_loaded,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_WAIT_LEN = 3'd0,
    S_DATA     = 3'd1,
    S_CSUM     = 3'd2,
    S_ERR      = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  localparam logic [8:0]  MAX_WORDS = 9'(MEM_BYTES / 4);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  state_t        state;
  logic [AW:0]   byte_cnt;
  logic [AW:0]   target;
  logic [7:0]    csum_acc;

  logic          xfer;
  logic          len_ok;
  logic [AW:0]   len_bytes;
  logic [AW:0]   cnt_next;

  assign xfer      = host.in_valid & host.in_ready;
  assign len_ok    = (host.in_data != 8'd0) && ({1'b0, host.in_data} <= MAX_WORDS);
  // Only evaluated when len_ok, so the word count always fits before the shift.
  assign len_bytes = (AW+1)'({host.in_data, 2'b00});
  assign cnt_next  = byte_cnt + CNT_ONE;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_WAIT_LEN;
      host.in_ready <= 1'b1;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      bytes_loaded  <= '0;
      byte_cnt      <= '0;
      target        <= '0;
      csum_acc      <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        // ERR re-frames: its next byte is a fresh length byte.
        S_WAIT_LEN, S_ERR: begin
          cpu_hold      <= 1'b1;
          host.in_ready <= 1'b1;
          if (xfer) begin
            if (len_ok) begin
              target       <= len_bytes;
              byte_cnt     <= '0;
              csum_acc     <= '0;
              bytes_loaded <= '0;
              load_err     <= 1'b0;
              state        <= S_DATA;
            end else begin
              load_err <= 1'b1;
              state    <= S_ERR;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we       <= 1'b1;
            mem_addr     <= byte_cnt[AW-1:0];
            mem_wdata    <= host.in_data;
            byte_cnt     <= cnt_next;
            bytes_loaded <= bytes_loaded + CNT_ONE;
            csum_acc     <= csum_acc ^ host.in_data;
            if (cnt_next == target) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (host.in_data == csum_acc) begin
              state         <= S_RUN;
              load_done     <= 1'b1;
              cpu_hold      <= 1'b0;
              host.in_ready <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cpu_hold      <= 1'b0;
          host.in_ready <= 1'b0;
          if (reload_req) begin
            cpu_hold      <= 1'b1;
            host.in_ready <= 1'b1;
            state         <= S_WAIT_LEN;
          end
        end
        default: begin
          cpu_hold      <= 1'b1;
          host.in_ready <= 1'b1;
          state         <= S_WAIT_LEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized frame-level bench for imem_boot_loader: writes and done pulses are predicted
// from the frame contents and checked by an independent output monitor.
module tb_imem_boot_loader;
  localparam int MEM_BYTES = 128;
  localparam int AW        = 7;
  localparam int MAXW      = MEM_BYTES / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reload_req = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   bytes_loaded;
  logic [2:0]    state_dbg;

  imem_boot_loader_if host ();

  imem_boot_loader #(.MEM_BYTES(MEM_BYTES), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host),
    .reload_req   (reload_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .bytes_loaded (bytes_loaded),
    .state_dbg    (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state: {cycle[15:0], addr[7:0], data[7:0]}
  logic [31:0] exp_q[$];
  int          done_q[$];
  logic [7:0]  frame_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          in_run = 1'b0;
  int          last_loaded = 0;
  logic [31:0] mon_e;
  int          mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every write strobe and done pulse must match a queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_mem_we", 32'(mem_we), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e[15:8]));
          check("wr_data", 32'(mem_wdata), 32'(mon_e[7:0]));
          check("wr_latency", 32'(cyc[15:0]), 32'(mon_e[31:16]));
        end
      end
      if (load_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_load_done", 32'(load_done), 32'd0);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_d));
          check("hold_release_at_done", 32'(cpu_hold), 32'd0);
        end
      end
    end
  end

  // driver: present one byte, wait for acceptance, record expectations tagged with its cycle
  task automatic send_byte(input logic [7:0] b, input bit wr, input int addr, input bit done);
    int g;
    g = 0;
    @(negedge clk);
    host.in_valid = 1'b1;
    host.in_data  = b;
    while (!host.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!host.in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      host.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    host.in_valid = 1'b0;
    if (wr)   exp_q.push_back({cyc[15:0], 8'(addr), b});
    if (done) done_q.push_back(cyc);
  endtask

  task automatic build_frame(input int l, input bit bad_csum);
    logic [7:0] b;
    logic [7:0] x;
    frame_q.delete();
    frame_q.push_back(8'(l));
    if (l >= 1 && l <= MAXW) begin
      x = 8'h00;
      for (int i = 0; i < 4 * l; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        x = x ^ b;
      end
      frame_q.push_back(bad_csum ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
    end
  endtask

  // reference model: outcome of a frame follows from its length byte and payload XOR
  task automatic send_frame(input int gap_max);
    int         l;
    int         n;
    bit         legal;
    bit         ok;
    logic [7:0] x;
    l     = int'(frame_q[0]);
    legal = (l >= 1) && (l <= MAXW);
    n     = legal ? 4 * l : 0;
    x     = 8'h00;
    for (int i = 1; i <= n; i++) x = x ^ frame_q[i];
    ok = legal && (frame_q.size() > n + 1) && (frame_q[n+1] == x);
    for (int i = 0; i < frame_q.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      send_byte(frame_q[i], legal && i >= 1 && i <= n, i - 1, ok && i == n + 1);
      if (i == 0) begin
        if (legal) begin
          check("len_clears_err", 32'(load_err), 32'd0);
          check("len_clears_count", 32'(bytes_loaded), 32'd0);
        end else begin
          check("bad_len_sets_err", 32'(load_err), 32'd1);
        end
      end
    end
    if (legal) last_loaded = n;
    repeat (2) @(negedge clk);
    check("bytes_loaded", 32'(bytes_loaded), 32'(last_loaded));
    if (ok) begin
      check("done_seen", 32'(done_q.size()), 32'd0);
      check("run_hold", 32'(cpu_hold), 32'd0);
      check("run_ready", 32'(host.in_ready), 32'd0);
      check("run_err", 32'(load_err), 32'd0);
      in_run = 1'b1;
    end else begin
      check("err_flag", 32'(load_err), 32'd1);
      check("err_hold", 32'(cpu_hold), 32'd1);
      check("err_ready", 32'(host.in_ready), 32'd1);
      in_run = 1'b0;
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload_req = 1'b1;
    @(posedge clk);
    #1;
    reload_req = 1'b0;
    check("reload_hold", 32'(cpu_hold), 32'd1);
    check("reload_ready", 32'(host.in_ready), 32'd1);
    check("reload_keeps_count", 32'(bytes_loaded), 32'(last_loaded));
    in_run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    host.in_valid = 1'b0;
    host.in_data  = 8'h00;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(host.in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_bytes_loaded", 32'(bytes_loaded), 32'd0);
    rst = 1'b0;

    // nominal frame, back to back
    frame_q = '{8'h02, 8'h0A, 8'h30, 8'h04, 8'h13, 8'hFF, 8'hC1, 8'h01, 8'h13, 8'h01};
    send_frame(0);

    // same frame with host gaps
    do_reload();
    frame_q = '{8'h02, 8'h0A, 8'h30, 8'h04, 8'h13, 8'hFF, 8'hC1, 8'h01, 8'h13, 8'h01};
    send_frame(5);

    // bad checksum, then the corrected frame
    do_reload();
    frame_q = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h33, 8'hFF};
    send_frame(0);
    frame_q = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h33, 8'h37};
    send_frame(1);

    // illegal lengths, then a full-memory frame
    do_reload();
    frame_q = '{8'h00};
    send_frame(0);
    frame_q = '{8'h21};
    send_frame(0);
    build_frame(MAXW, 1'b0);
    send_frame(1);

    // bytes offered in RUN are not consumed
    @(negedge clk);
    host.in_valid = 1'b1;
    host.in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("run_ignores_ready", 32'(host.in_ready), 32'd0);
    check("run_ignores_count", 32'(bytes_loaded), 32'(last_loaded));
    host.in_valid = 1'b0;

    // asynchronous reset after the third payload byte
    do_reload();
    send_byte(8'h02, 1'b0, 0, 1'b0);
    send_byte(8'h11, 1'b1, 0, 1'b0);
    send_byte(8'h22, 1'b1, 1, 1'b0);
    send_byte(8'h33, 1'b1, 2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mem_we", 32'(mem_we), 32'd0);
    check("async_rst_hold", 32'(cpu_hold), 32'd1);
    check("async_rst_ready", 32'(host.in_ready), 32'd1);
    check("async_rst_count", 32'(bytes_loaded), 32'd0);
    check("async_rst_addr", 32'(mem_addr), 32'd0);
    check("async_rst_wdata", 32'(mem_wdata), 32'd0);
    exp_q.delete();
    done_q.delete();
    last_loaded = 0;
    @(negedge clk);
    rst = 1'b0;
    build_frame(2, 1'b0);
    send_frame(2);

    // random frames: legal and illegal lengths, good and bad checksums
    for (int k = 0; k < 14; k++) begin
      if (in_run) do_reload();
      if ($urandom_range(9, 0) == 0)
        l = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, MAXW + 1));
      else
        l = int'($urandom_range(MAXW, 1));
      build_frame(l, $urandom_range(3, 0) == 0);
      send_frame(int'($urandom_range(3, 0)));
    end

    repeat (3) @(negedge clk);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("dones_drained", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
